// File: rtl/nist_pkg.sv
// Shared types and default sizing for the NIST test sequencer.
package nist_pkg;
    localparam int NTESTS_DEF     = 4;
    localparam int N_BITS_DEF     = 16384;
    localparam int CLR_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_CLEAR  = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/next_test_sel.sv
// Picks the lowest-index set bit of the pending-test mask.
module next_test_sel #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
                any_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/nist_counter.sv
// Up-counter with synchronous clear that saturates at MAX instead of wrapping.
module nist_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          cnt_q <= '0;
        else if (clr_i)                     cnt_q <= '0;
        else if (en_i && cnt_q != W'(MAX))  cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/nist_test_sequencer.sv
// Runs each enabled NIST test engine in turn: reset hold, then N_BITS random bits.
module nist_test_sequencer
    import nist_pkg::*;
#(
    parameter int N_BITS     = N_BITS_DEF,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int NTESTS     = NTESTS_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [NTESTS-1:0] test_en,
    input  logic              rnd_in,
    input  logic [NTESTS-1:0] err_in,
    output logic              rnd_out,
    output logic [NTESTS-1:0] test_rstn,
    output logic [1:0]        cur_test,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NTESTS-1:0] fail_map
);
    localparam int IW = 2;
    localparam int BW = $clog2(N_BITS + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    state_t            state_q;
    logic [NTESTS-1:0] pend_q, fail_q, trst_q;
    logic [IW-1:0]     cur_q, sel_idx;
    logic              busy_q, done_q, pass_q, sel_any;
    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     clr_cnt;

    next_test_sel #(.N(NTESTS), .IW(IW)) u_sel (
        .mask_i (pend_q),
        .idx_o  (sel_idx),
        .any_o  (sel_any)
    );

    // Each counter is held clear in the state preceding the one it times.
    nist_counter #(.W(CW), .MAX(CLR_CYCLES)) u_clr_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (state_q == S_SELECT),
        .en_i  (state_q == S_CLEAR),
        .cnt_o (clr_cnt)
    );

    nist_counter #(.W(BW), .MAX(N_BITS)) u_bit_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (state_q == S_CLEAR),
        .en_i  (state_q == S_RUN),
        .cnt_o (bit_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            fail_q  <= '0;
            trst_q  <= '0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
                trst_q  <= '0;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        pend_q  <= test_en;
                        fail_q  <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SELECT;
                    end
                    S_SELECT: if (sel_any) begin
                        cur_q           <= sel_idx;
                        pend_q[sel_idx] <= 1'b0;
                        state_q         <= S_CLEAR;
                    end else begin
                        done_q  <= 1'b1;
                        pass_q  <= ~|fail_q;
                        state_q <= S_DONE;
                    end
                    S_CLEAR: if (clr_cnt == CLR_LAST) begin
                        trst_q  <= {{(NTESTS-1){1'b0}}, 1'b1} << cur_q;
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        if (err_in[cur_q]) fail_q[cur_q] <= 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            trst_q  <= '0;
                            state_q <= S_SELECT;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rnd_out   = rnd_in & (state_q == S_RUN);
    assign test_rstn = trst_q;
    assign cur_test  = cur_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_map  = fail_q;
endmodule
